// File: rtl/slot_free_list_if.sv
// slot_free_list_if: issue/return/flush bundle between dispatch, commit and the slot free list.
interface slot_free_list_if #(parameter int N = 32, parameter int IDX_W = $clog2(N));
   logic             flush;
   logic             alloc_req;
   logic             alloc_gnt;
   logic [IDX_W-1:0] alloc_idx;
   logic             rel0_vld;
   logic [IDX_W-1:0] rel0_idx;
   logic             rel1_vld;
   logic [IDX_W-1:0] rel1_idx;
   logic [IDX_W:0]   free_cnt;
   logic             empty;
   logic             rel_err;
   modport master (output flush, alloc_req, rel0_vld, rel0_idx, rel1_vld, rel1_idx,
                   input alloc_gnt, alloc_idx, free_cnt, empty, rel_err);
   modport slave  (input flush, alloc_req, rel0_vld, rel0_idx, rel1_vld, rel1_idx,
                   output alloc_gnt, alloc_idx, free_cnt, empty, rel_err);
endinterface

// File: rtl/slot_free_list.sv
// slot_free_list: bitmap slot pool; grants the lowest free index per cycle, takes back up to two slots.
// Slot i lives at free_map[N-1-i], so the lowest index is the most significant set bit.
module slot_free_list #(parameter int N = 32, parameter int IDX_W = $clog2(N)) (
   input logic clk,
   input logic rst_n,
   slot_free_list_if.slave bus
);
   logic [N-1:0]     free_map, alloc_mask, d0, d1, map_next;
   logic [IDX_W-1:0] sel, alloc_idx;
   logic [IDX_W:0]   free_cnt, cnt_next;
   logic             taken, ok0, ok1, alloc_gnt, empty, rel_err;
   always_comb begin
      sel = '0;
      for (int i = N - 1; i >= 0; i--) if (free_map[N-1-i]) sel = IDX_W'(i);
      taken = bus.alloc_req && |free_map;
      alloc_mask = '0;
      d0 = '0;
      d1 = '0;
      for (int i = 0; i < N; i++) begin
         alloc_mask[N-1-i] = taken && sel == IDX_W'(i);
         d0[N-1-i] = bus.rel0_idx == IDX_W'(i);
         d1[N-1-i] = bus.rel1_idx == IDX_W'(i);
      end
      // a return is legal only for an in-range, currently allocated slot; a slot being granted is still free here
      ok0 = bus.rel0_vld && |(d0 & ~free_map);
      ok1 = bus.rel1_vld && |(d1 & ~free_map) && !(bus.rel0_vld && bus.rel0_idx == bus.rel1_idx);
      map_next = (free_map & ~alloc_mask) | (ok0 ? d0 : '0) | (ok1 ? d1 : '0);
      cnt_next = free_cnt - (IDX_W+1)'(taken) + (IDX_W+1)'(ok0) + (IDX_W+1)'(ok1);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         free_map  <= '1;
         free_cnt  <= (IDX_W+1)'(N);
         empty     <= 1'b0;
         alloc_gnt <= 1'b0;
         alloc_idx <= '0;
         rel_err   <= 1'b0;
      end else if (bus.flush) begin
         free_map  <= '1;
         free_cnt  <= (IDX_W+1)'(N);
         empty     <= 1'b0;
         alloc_gnt <= 1'b0;
         rel_err   <= 1'b0;
      end else begin
         free_map  <= map_next;
         free_cnt  <= cnt_next;
         empty     <= cnt_next == '0;
         alloc_gnt <= taken;
         if (taken) alloc_idx <= sel;
         rel_err   <= (bus.rel0_vld && !ok0) || (bus.rel1_vld && !ok1);
      end
   assign bus.alloc_gnt = alloc_gnt;
   assign bus.alloc_idx = alloc_idx;
   assign bus.free_cnt  = free_cnt;
   assign bus.empty     = empty;
   assign bus.rel_err   = rel_err;
endmodule

// File: tb/tb_slot_free_list.sv
// tb_slot_free_list: directed scenarios plus random traffic against a per-slot array model of the free list.
module tb_slot_free_list;
   localparam int N = 32;
   localparam int IDX_W = 5;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   slot_free_list_if #(.N(N), .IDX_W(IDX_W)) bus ();
   slot_free_list #(.N(N), .IDX_W(IDX_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   bit m_free [N];
   bit m_gnt, m_err;
   int m_idx;
   int checks = 0;
   int failures = 0;
   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_free[i]);
      return c;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic check_all(input string tag);
      chk({tag, ".gnt"}, 32'(bus.alloc_gnt), 32'(m_gnt));
      chk({tag, ".idx"}, 32'(bus.alloc_idx), 32'(m_idx));
      chk({tag, ".cnt"}, 32'(bus.free_cnt), 32'(m_cnt()));
      chk({tag, ".empty"}, 32'(bus.empty), 32'(m_cnt() == 0));
      chk({tag, ".err"}, 32'(bus.rel_err), 32'(m_err));
   endtask
   task automatic model_reset();
      for (int i = 0; i < N; i++) m_free[i] = 1'b1;
      m_gnt = 1'b0;
      m_err = 1'b0;
      m_idx = 0;
   endtask
   task automatic drive_idle();
      bus.flush = 1'b0;
      bus.alloc_req = 1'b0;
      bus.rel0_vld = 1'b0;
      bus.rel0_idx = '0;
      bus.rel1_vld = 1'b0;
      bus.rel1_idx = '0;
   endtask
   task automatic step(input bit req, input bit v0, input int i0, input bit v1, input int i1,
                       input bit fl, input string tag);
      int j;
      bit ok0, ok1;
      @(negedge clk);
      bus.flush = fl;
      bus.alloc_req = req;
      bus.rel0_vld = v0;
      bus.rel0_idx = IDX_W'(i0);
      bus.rel1_vld = v1;
      bus.rel1_idx = IDX_W'(i1);
      if (fl) begin
         for (int i = 0; i < N; i++) m_free[i] = 1'b1;
         m_gnt = 1'b0;
         m_err = 1'b0;
      end else begin
         j = -1;
         if (req) for (int i = N - 1; i >= 0; i--) if (m_free[i]) j = i;
         ok0 = v0 && i0 < N && !m_free[i0];
         ok1 = v1 && i1 < N && !m_free[i1] && !(v0 && i0 == i1);
         m_err = (v0 && !ok0) || (v1 && !ok1);
         m_gnt = j >= 0;
         if (j >= 0) begin
            m_free[j] = 1'b0;
            m_idx = j;
         end
         if (ok0) m_free[i0] = 1'b1;
         if (ok1) m_free[i1] = 1'b1;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask
   initial begin
      drive_idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 33; k++) step(1, 0, 0, 0, 0, 0, "t1_alloc");
      chk("t1_empty", 32'(bus.empty), 32'd1);
      step(0, 1, 7, 1, 3, 0, "t2_rel");
      chk("t2_cnt", 32'(bus.free_cnt), 32'd2);
      step(1, 0, 0, 0, 0, 0, "t2_a1");
      chk("t2_first", 32'(bus.alloc_idx), 32'd3);
      step(1, 0, 0, 0, 0, 0, "t2_a2");
      chk("t2_second", 32'(bus.alloc_idx), 32'd7);
      step(0, 1, 5, 0, 0, 0, "t3_free5");
      step(1, 1, 2, 0, 0, 0, "t3_mix");
      chk("t3_idx", 32'(bus.alloc_idx), 32'd5);
      chk("t3_cnt", 32'(bus.free_cnt), 32'd1);
      step(1, 0, 0, 0, 0, 0, "t3_next");
      chk("t3_next_idx", 32'(bus.alloc_idx), 32'd2);
      step(0, 1, 9, 1, 9, 0, "t4_dup");
      chk("t4_dup_err", 32'(bus.rel_err), 32'd1);
      step(0, 1, 9, 0, 0, 0, "t4_again");
      step(0, 0, 0, 0, 0, 0, "t4_idle");
      step(0, 0, 0, 0, 0, 1, "t5_pre");
      for (int k = 0; k < 10; k++) step(1, 0, 0, 0, 0, 0, "t5_alloc");
      step(1, 1, 3, 0, 0, 1, "t5_flush");
      chk("t5_cnt", 32'(bus.free_cnt), 32'd32);
      step(1, 0, 0, 0, 0, 0, "t6_grant");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("t6_async");
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, 0, 0, 0, "t6_after");
      chk("t6_idx0", 32'(bus.alloc_idx), 32'd0);
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, int'($urandom_range(0, N - 1)),
              $urandom_range(0, 9) < 4, int'($urandom_range(0, N - 1)), $urandom_range(0, 99) < 2, "rand");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
